// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the hex display controller: segment font, blank pattern
// and digit width.
package hex_display_ctrl_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    // Active-low font, bit order g..a, index = nibble value.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_display_ctrl_seg_decode.sv
// Combinational nibble-to-segment decoder with blank override.
import hex_display_ctrl_pkg::*;

module hex_seg_decode (
    input  logic [DIGIT_W-1:0] val,
    input  logic               blank,
    output logic [6:0]         seg
);

    assign seg = blank ? BLANK_SEG : SEG_FONT[val];

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display controller: capture register, leading-zero blanking, blink,
// direct-drive segments and a scanned multiplexed output.
import hex_display_ctrl_pkg::*;

module hex_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    input  logic                        load,
    input  logic                        blank_lz,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    output logic                        load_ack,
    output logic [7*NUM_DIGITS-1:0]     HEX,
    output logic [6:0]                  seg_mux,
    output logic [NUM_DIGITS-1:0]       dig_sel
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW    = $clog2(BLINK_DIV);
    localparam int SW    = $clog2(SCAN_DIV);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] disp_q, disp_d;
    logic                               cap_q, cap_d;
    logic                               ack_q, ack_d;
    logic [BW-1:0]                      blink_cnt_q, blink_cnt_d;
    logic                               blink_phase_q, blink_phase_d;
    logic [SW-1:0]                      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]                   scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0][6:0]         hex_q, hex_d;
    logic [6:0]                         seg_mux_q, seg_mux_d;
    logic [NUM_DIGITS-1:0]              dig_sel_q, dig_sel_d;

    logic [NUM_DIGITS-1:0]              blank_vec;
    logic [NUM_DIGITS-1:0][6:0]         seg_w;
    logic                               all_zero;
    logic                               blink_wrap, scan_wrap;

    // Walk from the top digit down; a digit is a leading zero while every
    // digit above it (and itself) is zero. Digit 0 is always shown.
    always_comb begin
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero & (disp_q[k] == '0);
            blank_vec[k] = (blank_lz & all_zero & (k != 0))
                         | (blink_mask[k] & ~blink_phase_q);
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        hex_seg_decode u_dec (
            .val   (disp_q[k]),
            .blank (blank_vec[k]),
            .seg   (seg_w[k])
        );
    end

    always_comb begin
        disp_d        = load ? data_in : disp_q;
        cap_d         = load;
        ack_d         = cap_q;

        blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;

        scan_wrap     = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        if (scan_wrap)
            scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;

        // Direct and muxed outputs register from the same decode and index,
        // so seg_mux always matches the selected HEX slice.
        hex_d                 = seg_w;
        seg_mux_d             = seg_w[scan_idx_q];
        dig_sel_d             = '1;
        dig_sel_d[scan_idx_q] = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            disp_q        <= '0;
            cap_q         <= 1'b0;
            ack_q         <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            hex_q         <= {NUM_DIGITS{BLANK_SEG}};
            seg_mux_q     <= BLANK_SEG;
            dig_sel_q     <= '1;
        end else begin
            disp_q        <= disp_d;
            cap_q         <= cap_d;
            ack_q         <= ack_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            hex_q         <= hex_d;
            seg_mux_q     <= seg_mux_d;
            dig_sel_q     <= dig_sel_d;
        end
    end

    assign load_ack = ack_q;
    assign HEX      = hex_q;
    assign seg_mux  = seg_mux_q;
    assign dig_sel  = dig_sel_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: 4-digit instance with fast dividers
// plus a single-digit instance.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic        load_ack;
    logic [27:0] hex;
    logic [6:0]  seg_mux;
    logic [3:0]  dig_sel;

    logic        load_ack1;
    logic [6:0]  hex1;
    logic [6:0]  seg_mux1;
    logic [0:0]  dig_sel1;

    int n_chk = 0;
    int n_err = 0;
    int ncyc;

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(3)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .load_ack   (load_ack),
        .HEX        (hex),
        .seg_mux    (seg_mux),
        .dig_sel    (dig_sel)
    );

    hex_display_ctrl #(.NUM_DIGITS(1), .BLINK_DIV(2), .SCAN_DIV(2)) dut1 (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .data_in    (data_in[3:0]),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (1'b0),
        .load_ack   (load_ack1),
        .HEX        (hex1),
        .seg_mux    (seg_mux1),
        .dig_sel    (dig_sel1)
    );

    // Edge count since reset release; drives the expected blink/scan timing.
    always @(posedge clk or negedge resetn)
        if (!resetn) ncyc <= 0;
        else         ncyc <= ncyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    logic [6:0] f4321 [4];
    int         idx;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        f4321 = '{7'h79, 7'h24, 7'h30, 7'h19};
        resetn = 1'b0; data_in = '0; load = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hex",     {4'h0, hex}, {4'h0, {4{7'h7F}}});
        chk("rst_segmux",  {25'h0, seg_mux}, 32'h7F);
        chk("rst_digsel",  {28'h0, dig_sel}, 32'hF);
        chk("rst_ack",     {31'h0, load_ack}, 32'h0);
        chk("rst_digsel1", {31'h0, dig_sel1}, 32'h1);

        // Capture with leading-zero blanking
        @(negedge clk);
        resetn = 1'b1;
        data_in = 16'h00A5; blank_lz = 1'b1; load = 1'b1;
        tick(); load = 1'b0;
        chk("ack_early", {31'h0, load_ack}, 32'h0);
        tick();
        chk("lz_00A5",   {4'h0, hex}, {4'h0, 7'h7F, 7'h7F, 7'h08, 7'h12});
        chk("ack_pulse", {31'h0, load_ack}, 32'h1);
        tick();
        chk("ack_drop",  {31'h0, load_ack}, 32'h0);
        blank_lz = 1'b0;
        tick();
        chk("nolz_00A5", {4'h0, hex}, {4'h0, 7'h40, 7'h40, 7'h08, 7'h12});
        data_in = 16'h0000; blank_lz = 1'b1; load = 1'b1;
        tick(); load = 1'b0;
        tick();
        chk("lz_0000",   {4'h0, hex}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Back-to-back loads, last value wins
        data_in = 16'h1111; load = 1'b1;
        tick(); data_in = 16'h2222;
        tick(); load = 1'b0;
        chk("b2b_ack1",  {31'h0, load_ack}, 32'h1);
        chk("b2b_hex1",  {4'h0, hex}, {4'h0, {4{7'h79}}});
        tick();
        chk("b2b_ack2",  {31'h0, load_ack}, 32'h1);
        chk("b2b_hex2",  {4'h0, hex}, {4'h0, {4{7'h24}}});
        tick();
        chk("b2b_ack3",  {31'h0, load_ack}, 32'h0);
        data_in = 16'h9999;
        repeat (20) tick();
        chk("hold_hex",  {4'h0, hex}, {4'h0, {4{7'h24}}});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nd1_digsel", {31'h0, dig_sel1}, 32'h0);
            chk("nd1_hex",    {25'h0, hex1}, 32'h24);
            chk("nd1_segmux", {25'h0, seg_mux1}, 32'h24);
        end

        // Blink on digit 0
        do_reset();
        blink_mask = 4'b0001; blank_lz = 1'b0; data_in = 16'h8888; load = 1'b1;
        tick(); load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("blink_d0",  {25'h0, hex[6:0]}, ((((ncyc - 1) / 4) % 2) == 1) ? 32'h7F : 32'h00);
            chk("blink_d31", {11'h0, hex[27:7]}, 32'h0);
        end

        // Scan walk
        do_reset();
        blink_mask = 4'b0000; data_in = 16'h4321; load = 1'b1;
        tick(); load = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            idx = ((ncyc - 1) / 3) % 4;
            chk("scan_digsel", {28'h0, dig_sel}, {28'h0, ~(4'b0001 << idx)});
            chk("scan_segmux", {25'h0, seg_mux}, {25'h0, f4321[idx]});
        end

        // Load, scan wrap and blink toggle on one edge (edge 12)
        do_reset();
        blink_mask = 4'b0010; data_in = 16'hB8D5;
        repeat (11) tick();
        chk("coin_before", {4'h0, hex}, {4'h0, {4{7'h40}}});
        load = 1'b1;
        tick(); load = 1'b0;
        chk("coin_ack0",   {31'h0, load_ack}, 32'h0);
        tick();
        chk("coin_hex",    {4'h0, hex}, {4'h0, 7'h03, 7'h00, 7'h7F, 7'h12});
        chk("coin_digsel", {28'h0, dig_sel}, 32'hE);
        chk("coin_segmux", {25'h0, seg_mux}, 32'h12);
        chk("coin_ack1",   {31'h0, load_ack}, 32'h1);

        // Asynchronous reset mid-cycle while ack is high
        #1 resetn = 1'b0;
        #1;
        chk("arst_hex",    {4'h0, hex}, {4'h0, {4{7'h7F}}});
        chk("arst_segmux", {25'h0, seg_mux}, 32'h7F);
        chk("arst_digsel", {28'h0, dig_sel}, 32'hF);
        chk("arst_ack",    {31'h0, load_ack}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of hex digits (range 1..8).
REQ-002 Parameter BLINK_DIV, default 25000000, SHALL set the clock cycles per blink half-period (minimum 2).
REQ-003 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles per scan slot (minimum 2).
REQ-004 CLOCK_50  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 resetn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 data_in  in  4*NUM_DIGITS  SHALL carry the hex value; nibble k is digit k, and digit 0 is least significant.
REQ-007 load  in  1  SHALL capture data_in into the display register when high at a clock edge.
REQ-008 blank_lz  in  1  SHALL enable leading-zero blanking.
REQ-009 blink_mask  in  NUM_DIGITS  SHALL select which digits blink.
REQ-010 load_ack  out  1  SHALL pulse high for one cycle after each capture.
REQ-011 HEX  out  7*NUM_DIGITS  SHALL provide direct-drive segments, active-low; bits [7k+6:7k] are digit k, ordered g..a (bit 0 = a).
REQ-012 seg_mux  out  7  SHALL provide the multiplexed segments of the currently scanned digit, active-low.
REQ-013 dig_sel  out  NUM_DIGITS  SHALL provide the scan digit enable, active-low and one-hot.

Function
REQ-014 Decode SHALL use the standard active-low hex font: 0=1000000, 5=0010010, 8=0000000, A=0001000, b=0000011, d=0100001, F=0001110.
REQ-015 A blanked digit SHALL output 1111111.
REQ-016 Capture: on a load edge, the display register takes data_in; HEX and seg_mux reflect the new value on the following edge (one-cycle latency, all outputs registered).
REQ-017 load_ack SHALL assert on the edge after capture and last exactly one cycle; back-to-back load cycles give back-to-back acks, with the last value winning.
REQ-018 With load low, the display register SHALL hold its value indefinitely.
REQ-019 Leading-zero blanking: with blank_lz=1, digit k>0 SHALL blank iff it and all higher digits are zero; digit 0 never blanks under this rule.
REQ-020 blank_lz SHALL act on the registered value combinationally and appear at the outputs one cycle after it changes.
REQ-021 The blink counter SHALL count 0..BLINK_DIV-1, wrap, and toggle blink_phase at each wrap.
REQ-022 Digit k SHALL be blanked when blink_mask[k]=1 and blink_phase=0.
REQ-023 The scan counter SHALL count 0..SCAN_DIV-1; at its wrap, scan_idx advances by one, going from NUM_DIGITS-1 back to 0.
REQ-024 dig_sel[scan_idx]=0, all other bits of dig_sel=1, and seg_mux shall equal the HEX slice for scan_idx, all registered together with no mismatched cycle.
REQ-025 Capture, blink toggle and scan advance coinciding on one edge SHALL all take effect on that edge, independently.
REQ-026 With NUM_DIGITS=1, dig_sel SHALL be constantly 0 and scan_idx constantly 0.

Reset
REQ-027 While resetn=0: display register=0, blink counter=0, blink_phase=1, scan counter=0, scan_idx=0, load_ack=0.
REQ-028 While resetn=0, outputs SHALL be: HEX all digits =1111111, seg_mux=1111111, dig_sel all 1s.
REQ-029 A load coinciding with reset release SHALL be ignored.
REQ-030 Reset asserted mid-blink or mid-scan SHALL abort the operation immediately, with no partial ack.

Structure
REQ-031 The shared package SHALL hold the 16-entry segment font constant, the BLANK_SEG constant (1111111) and the digit-width constant (4).
REQ-032 One sub-module, hex_seg_decode, SHALL be purely combinational (4-bit value plus blank in, 7-bit active-low segments out) and instantiated NUM_DIGITS times.
REQ-033 The counters, capture register and scan mux SHALL reside in hex_display_ctrl.

Verification
REQ-034 Reset release, then NUM_DIGITS=4, load data_in=16'h00A5 with blank_lz=1 -> next cycle HEX = {1111111, 1111111, 0001000, 0010010}, and load_ack high exactly one cycle.
REQ-035 Same value with blank_lz=0 -> digits 3,2 = 1000000; and data_in=16'h0000 with blank_lz=1 -> digits 3..1 blank, digit 0 = 1000000.
REQ-036 BLINK_DIV=4, blink_mask=4'b0001, value 16'h8888 -> digit 0 alternates 0000000 / 1111111 every 4 cycles; digits 3..1 remain steady at 0000000.
REQ-037 SCAN_DIV=3 -> dig_sel walks 1110, 1101, 1011, 0111, 1110 every 3 cycles, with seg_mux matching the selected HEX slice each cycle.
REQ-038 A load on the same edge as a scan wrap and a blink toggle -> all three effects are visible on the next cycle; resetn pulsed low mid-scan -> the reset values of REQ-027/REQ-028 appear immediately, without waiting for a clock edge.
